// File: rtl/execute_unit_pkg.sv
// Shared types and constants for the execute stage: opcodes, FSM states,
// default widths and the multiplier iteration count. EXEC_MUL_EN adds MUL state.
package exec_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int SEL_W_DEF = 2;
    localparam int OP_W      = 3;
    localparam int MUL_ITERS = 64;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_SLL = 3'b101;
    localparam logic [OP_W-1:0] OP_SRL = 3'b110;
    localparam logic [OP_W-1:0] OP_MUL = 3'b111;

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/execute_unit_if.sv
// Request handshake plus register-file write port of the execute stage.
// master: issue side (drives inValid/opcode/opA/opB/destSel); slave: execute_unit.
interface execute_unit_if #(
    parameter int WIDTH = exec_pkg::WIDTH_DEF,
    parameter int SEL_W = exec_pkg::SEL_W_DEF
);
    import exec_pkg::*;

    logic             inValid;
    logic             inReady;
    logic [OP_W-1:0]  opcode;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [SEL_W-1:0] destSel;
    logic [SEL_W-1:0] selWrite;
    logic [WIDTH-1:0] writeIn;
    logic             isReading;
    logic             busy;
    logic             illegal;

    modport master (
        output inValid, opcode, opA, opB, destSel,
        input  inReady, selWrite, writeIn, isReading, busy, illegal
    );

    modport slave (
        input  inValid, opcode, opA, opB, destSel,
        output inReady, selWrite, writeIn, isReading, busy, illegal
    );

endinterface

// File: rtl/execute_unit_iter_multiplier.sv
// Radix-2 shift-add multiplier, one iteration per clock, fixed ITERS iterations.
// Ports: clk, rstN, start (load operands), multiplicandIn, multiplierIn, done, product.
module iter_multiplier
    import exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITERS = MUL_ITERS
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicandIn,
    input  logic [WIDTH-1:0] multiplierIn,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    logic             active;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] accNext;

    always_comb begin
        accNext = acc;
        if (mplier[0]) begin
            accNext = acc + mcand;
        end
    end

    // done and product describe the iteration happening at this edge, so
    // the caller can capture the final sum on the same edge.
    assign done    = active && (count == LAST);
    assign product = accNext;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            active <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            active <= 1'b1;
            count  <= '0;
            mcand  <= multiplicandIn;
            mplier <= multiplierIn;
            acc    <= '0;
        end else if (active) begin
            acc    <= accNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: ALU / iterative MUL feeding the register-file write port.
// Ports: clk, rstN, bus (execute_unit_if.slave). Macro EXEC_MUL_EN enables MUL.
module execute_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic           clk,
    input  logic           rstN,
    execute_unit_if.slave  bus
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state;
    logic             inReadyQ;
    logic             busyQ;
    logic             isReadingQ;
    logic             illegalQ;
    logic [SEL_W-1:0] selWriteQ;
    logic [WIDTH-1:0] writeInQ;
    logic [WIDTH-1:0] aluRes;
    logic [SH_W-1:0]  shamt;
    logic             accept;

    assign accept = bus.inValid && inReadyQ;
    assign shamt  = bus.opB[SH_W-1:0];

    always_comb begin
        aluRes = '0;
        unique case (bus.opcode)
            OP_ADD:  aluRes = bus.opA + bus.opB;
            OP_SUB:  aluRes = bus.opA - bus.opB;
            OP_AND:  aluRes = bus.opA & bus.opB;
            OP_OR:   aluRes = bus.opA | bus.opB;
            OP_XOR:  aluRes = bus.opA ^ bus.opB;
            OP_SLL:  aluRes = bus.opA << shamt;
            OP_SRL:  aluRes = bus.opA >> shamt;
            default: aluRes = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic             mulStart;
    logic             mulDone;
    logic [WIDTH-1:0] mulProduct;
    logic [SEL_W-1:0] destQ;

    assign mulStart = accept && (bus.opcode == OP_MUL);

    iter_multiplier #(
        .WIDTH(WIDTH),
        .ITERS(MUL_ITERS)
    ) uMul (
        .clk           (clk),
        .rstN          (rstN),
        .start         (mulStart),
        .multiplicandIn(bus.opA),
        .multiplierIn  (bus.opB),
        .done          (mulDone),
        .product       (mulProduct)
    );
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            inReadyQ   <= 1'b1;
            busyQ      <= 1'b0;
            isReadingQ <= 1'b1;
            illegalQ   <= 1'b0;
            selWriteQ  <= '0;
            writeInQ   <= '0;
`ifdef EXEC_MUL_EN
            destQ      <= '0;
`endif
        end else begin
            illegalQ <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.opcode == OP_MUL) begin
`ifdef EXEC_MUL_EN
                            destQ    <= bus.destSel;
                            state    <= MUL;
                            inReadyQ <= 1'b0;
                            busyQ    <= 1'b1;
`else
                            // No multiplier: reject, stay ready.
                            illegalQ <= 1'b1;
`endif
                        end else begin
                            selWriteQ  <= bus.destSel;
                            writeInQ   <= aluRes;
                            isReadingQ <= 1'b0;
                            state      <= WB;
                            inReadyQ   <= 1'b0;
                            busyQ      <= 1'b1;
                        end
                    end
                end
`ifdef EXEC_MUL_EN
                MUL: begin
                    if (mulDone) begin
                        selWriteQ  <= destQ;
                        writeInQ   <= mulProduct;
                        isReadingQ <= 1'b0;
                        state      <= WB;
                    end
                end
`endif
                WB: begin
                    isReadingQ <= 1'b1;
                    inReadyQ   <= 1'b1;
                    busyQ      <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.inReady   = inReadyQ;
    assign bus.busy      = busyQ;
    assign bus.isReading = isReadingQ;
    assign bus.illegal   = illegalQ;
    assign bus.selWrite  = selWriteQ;
    assign bus.writeIn   = writeInQ;

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: cycle-level reference model with
// directed literal checks and randomized operation traffic.
module tb_execute_unit;

    logic clk = 1'b0;
    logic rstN = 1'b0;

    always #5 clk = ~clk;

    execute_unit_if #(.WIDTH(64), .SEL_W(2)) bus();

    execute_unit dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bus)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, got, exp);
        end
    endtask

    function automatic logic [63:0] refAlu(input logic [2:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << (b % 64);
            3'd6:    return a >> (b % 64);
            default: return a * b;
        endcase
    endfunction

    // Reference model: expected outputs after each edge.
    logic        mReady = 1'b1;
    logic        mBusy  = 1'b0;
    logic        mRd    = 1'b1;
    logic        mIll   = 1'b0;
    logic [1:0]  mSel   = 2'd0;
    logic [63:0] mData  = 64'd0;
`ifdef EXEC_MUL_EN
    int          mulLeft = 0;
    logic [63:0] pRes    = 64'd0;
    logic [1:0]  pDest   = 2'd0;
`endif

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mReady <= 1'b1;
            mBusy  <= 1'b0;
            mRd    <= 1'b1;
            mIll   <= 1'b0;
            mSel   <= 2'd0;
            mData  <= 64'd0;
`ifdef EXEC_MUL_EN
            mulLeft <= 0;
`endif
        end else begin
            mIll <= 1'b0;
            if (!mRd) begin
                mRd    <= 1'b1;
                mReady <= 1'b1;
                mBusy  <= 1'b0;
`ifdef EXEC_MUL_EN
            end else if (mulLeft > 0) begin
                mulLeft <= mulLeft - 1;
                if (mulLeft == 1) begin
                    mRd   <= 1'b0;
                    mSel  <= pDest;
                    mData <= pRes;
                end
`endif
            end else if (bus.inValid && mReady) begin
                if (bus.opcode == 3'd7) begin
`ifdef EXEC_MUL_EN
                    pRes    <= bus.opA * bus.opB;
                    pDest   <= bus.destSel;
                    mulLeft <= 64;
                    mReady  <= 1'b0;
                    mBusy   <= 1'b1;
`else
                    mIll <= 1'b1;
`endif
                end else begin
                    mData  <= refAlu(bus.opcode, bus.opA, bus.opB);
                    mSel   <= bus.destSel;
                    mRd    <= 1'b0;
                    mReady <= 1'b0;
                    mBusy  <= 1'b1;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("inReady", {63'd0, bus.inReady}, {63'd0, mReady});
        chk("busy", {63'd0, bus.busy}, {63'd0, mBusy});
        chk("isReading", {63'd0, bus.isReading}, {63'd0, mRd});
        chk("illegal", {63'd0, bus.illegal}, {63'd0, mIll});
        chk("selWrite", {62'd0, bus.selWrite}, {62'd0, mSel});
        chk("writeIn", bus.writeIn, mData);
    end

    task automatic waitReady();
        int n = 0;
        while (bus.inReady !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("readyTimeout", 64'd0, 64'd1);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [1:0] d);
        waitReady();
        bus.inValid = 1'b1;
        bus.opcode  = op;
        bus.opA     = a;
        bus.opB     = b;
        bus.destSel = d;
        @(negedge clk);
        bus.inValid = 1'b0;
    endtask

    function automatic logic [63:0] rndOperand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bus.inValid = 1'b0;
        bus.opcode  = 3'd0;
        bus.opA     = 64'd0;
        bus.opB     = 64'd0;
        bus.destSel = 2'd0;

        // Reset
        repeat (3) @(negedge clk);
        chk("rstIsReading", {63'd0, bus.isReading}, 64'd1);
        chk("rstInReady", {63'd0, bus.inReady}, 64'd1);
        chk("rstBusy", {63'd0, bus.busy}, 64'd0);
        chk("rstWriteIn", bus.writeIn, 64'd0);
        chk("rstSelWrite", {62'd0, bus.selWrite}, 64'd0);
        #2 rstN = 1'b1;
        @(negedge clk);
        chk("idleIsReading", {63'd0, bus.isReading}, 64'd1);

        // ADD wrap
        issue(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd1);
        chk("addWrapRd", {63'd0, bus.isReading}, 64'd0);
        chk("addWrapSel", {62'd0, bus.selWrite}, 64'd1);
        chk("addWrapData", bus.writeIn, 64'd0);
        @(negedge clk);
        chk("addOneCycle", {63'd0, bus.isReading}, 64'd1);

        // SUB and shifts
        issue(3'd1, 64'd5, 64'd7, 2'd2);
        chk("subData", bus.writeIn, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("subSel", {62'd0, bus.selWrite}, 64'd2);
        issue(3'd5, 64'd1, 64'd64, 2'd0);
        chk("sll64", bus.writeIn, 64'd1);
        chk("sllSel0", {62'd0, bus.selWrite}, 64'd0);
        issue(3'd6, 64'h8000_0000_0000_0000, 64'd63, 2'd3);
        chk("srl63", bus.writeIn, 64'd1);

`ifdef EXEC_MUL_EN
        // MUL with inValid junk held during the operation
        begin
            int lowCnt = 0;
            issue(3'd7, 64'hAFED, 64'h0777, 2'd3);
            bus.inValid = 1'b1;
            bus.opcode  = 3'd0;
            bus.opA     = 64'd1;
            bus.opB     = 64'd1;
            bus.destSel = 2'd0;
            while (bus.isReading === 1'b1 && lowCnt < 100) begin
                if (bus.inReady === 1'b0) lowCnt++;
                @(negedge clk);
            end
            if (bus.inReady === 1'b0) lowCnt++;
            chk("mulWbCycle", 64'(lowCnt), 64'd65);
            chk("mulData", bus.writeIn, 64'h0521_422B);
            chk("mulSel", {62'd0, bus.selWrite}, 64'd3);
            @(negedge clk);
            bus.inValid = 1'b0;
            chk("mulReadyAgain", {63'd0, bus.inReady}, 64'd1);
            @(negedge clk);
        end

        // Reset mid-MUL
        issue(3'd7, 64'h1234, 64'h5678, 2'd1);
        repeat (29) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("midMulRd", {63'd0, bus.isReading}, 64'd1);
        chk("midMulReady", {63'd0, bus.inReady}, 64'd1);
        chk("midMulBusy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        chk("postRstReady", {63'd0, bus.inReady}, 64'd1);
`else
        // Rejected opcode without multiplier
        issue(3'd7, 64'd3, 64'd4, 2'd2);
        chk("illPulse", {63'd0, bus.illegal}, 64'd1);
        chk("illNoWrite", {63'd0, bus.isReading}, 64'd1);
        chk("illReady", {63'd0, bus.inReady}, 64'd1);
        @(negedge clk);
        chk("illOneCycle", {63'd0, bus.illegal}, 64'd0);
`endif

        // Reset during WB
        issue(3'd2, 64'hF0F0, 64'hFF00, 2'd2);
        chk("andData", bus.writeIn, 64'hF000);
        #2 rstN = 1'b0;
        #1;
        chk("wbRstRd", {63'd0, bus.isReading}, 64'd1);
        chk("wbRstData", bus.writeIn, 64'd0);
        @(negedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.inValid = ($urandom_range(0, 9) < 6);
            bus.opcode  = 3'($urandom_range(0, 7));
            bus.opA     = rndOperand();
            bus.opB     = rndOperand();
            bus.destSel = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        bus.inValid = 1'b0;
        repeat (70) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
